piso_shift_register: RTL and testbench
======================================

Name: piso_shift_register

Overview:
- Parallel-in, serial-out transmitter. It is the sending end of the serial link that sipo_shift_register receives.
- It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, LSB-first or MSB-first per shift_dir.
- Bit order is chosen so that a sipo_shift_register with the same shift_dir holds the original word on parallel_out once all WIDTH bits have been shifted in.
- Supports back-to-back words with no idle gap, a stall input, and a per-word done pulse.

Parameters:
- WIDTH, 4: word width in bits; must be >= 2.
- IDLE_LEVEL, 1'b0: serial_out level when no word is being sent.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- parallel_in  input  WIDTH  word to transmit; sampled on the accept edge only.
- load_valid  input  1  parallel_in/shift_dir hold a word to send.
- load_ready  output  1  block can accept a word this cycle.
- shift_dir  input  1  0 = right shift (LSB first), 1 = left shift (MSB first); sampled on the accept edge.
- stall  input  1  freeze the shifter; current bit holds.
- serial_out  output  1  registered serial data.
- bit_valid  output  1  serial_out carries a live bit this cycle.
- bit_last  output  1  current bit is the final bit of the word.
- busy  output  1  word in flight.
- done  output  1  one-cycle pulse after a word's last bit completes.

Behaviour:
- Reset (reset=0, async): state=IDLE, serial_out=IDLE_LEVEL, bit_valid=0, bit_last=0, busy=0, done=0, bit counter=0, shift register=0.
- On release, load_ready=1.
- Reset mid-word aborts the word immediately; no done pulse is issued for it.
- States: IDLE, SHIFT.
- Accept = load_valid && load_ready at a rising edge.
- load_ready (combinational) = (state==IDLE) || (state==SHIFT && bit_last && !stall).
- IDLE -> SHIFT on accept:
  - Capture the word and the shift_dir value into dir_q.
  - serial_out = parallel_in[0] if shift_dir=0, else parallel_in[WIDTH-1].
  - bit_valid=1, busy=1, counter=0.
  - Latency: the first bit is valid in the cycle after the accept edge.
- SHIFT, stall=0, edge:
  - If not last: shift the register toward the output end (right if dir_q=0, left if dir_q=1) and present the next bit; counter += 1.
  - Bit i (0-based) appears i cycles after the first bit.
- bit_last = (state==SHIFT) && (counter==WIDTH-1).
- SHIFT, last bit, stall=0, edge:
  - done=1 for exactly the next cycle.
  - If accept on the same edge, the new word's first bit follows with no gap and the state stays SHIFT.
  - Otherwise go to IDLE: serial_out=IDLE_LEVEL, bit_valid=0, busy=0.
- SHIFT, stall=1:
  - serial_out, counter and shift register hold.
  - bit_valid=0 while stalled, so the receiver must not shift.
  - load_ready=0, even on the last bit.
  - busy stays 1.
- stall in IDLE has no effect; an accept in IDLE proceeds regardless of stall.
- shift_dir and parallel_in changes after the accept edge are ignored until the next accept.
- A word of WIDTH bits with no stall occupies exactly WIDTH bit_valid cycles.
- Counter width is $clog2(WIDTH); it wraps to 0 on each accept.

Test Plan (WIDTH=4, IDLE_LEVEL=0):
1. Reset, then load 4'b1011 with shift_dir=0 -> serial_out 1,1,0,1 on 4 consecutive cycles starting the cycle after accept; bit_valid high 4 cycles; bit_last on 4th; done pulses the cycle after; then IDLE with serial_out=0.
2. Load 4'b0110 with shift_dir=1 -> serial_out 0,1,1,0 (MSB first); toggling shift_dir mid-word changes nothing.
3. Hold load_valid=1 presenting 4'b1011 (dir 0) then 4'b0110 (dir 1) -> 8 contiguous bit_valid cycles 1,1,0,1,0,1,1,0 with no gap; load_ready high only in IDLE and on each bit_last; two done pulses.
4. Load 4'b1001 dir 0, stall=1 for 2 cycles during bit 1 -> serial_out holds 0 with bit_valid=0 for 2 cycles; resume gives 0,1; word spans 6 cycles; load_ready=0 throughout.
5. Load 4'b1111, drive reset=0 asynchronously mid-bit 2 -> serial_out=0, bit_valid=0, busy=0 immediately, no done pulse; after release, load 4'b0101 dir 0 -> full 1,0,1,0 sequence.
6. Loopback: serial_out into sipo_shift_register (same shift_dir, stall=0), send 4'b1101 dir 0 and 4'b1101 dir 1 -> receiver parallel_out==4'b1101 at the edge ending bit_last, both directions.

Source files
------------

// File: rtl/piso_shift_register.sv
// ---------------------------------------------------------------------------
// piso_shift_register : parallel-in serial-out transmitter with valid/ready
// load, stall, and per-word done pulse.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module piso_shift_register #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_dir,
  input  logic             stall,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             bit_last,
  output logic             busy,
  output logic             done
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic             dir_q;
  logic [CW-1:0]    cnt_q;
  logic             serial_q;
  logic             done_q;

  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_d;

  assign busy       = (state_q == SHIFT);
  assign bit_last   = busy && (cnt_q == LAST_IDX);
  assign bit_valid  = busy && !stall;
  assign load_ready = (state_q == IDLE) || (bit_last && !stall);
  assign accept     = load_valid && load_ready;
  assign serial_out = serial_q;
  assign done       = done_q;

  // The output end is bit 0 for right shifts and bit WIDTH-1 for left shifts.
  assign first_bit = shift_dir ? parallel_in[WIDTH-1] : parallel_in[0];
  assign next_bit  = dir_q ? shreg_q[WIDTH-2] : shreg_q[1];
  assign shreg_d   = dir_q ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      serial_q <= IDLE_LEVEL;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        // An accept while in SHIFT can only happen on an unstalled last bit.
        done_q   <= busy;
        state_q  <= SHIFT;
        shreg_q  <= parallel_in;
        dir_q    <= shift_dir;
        cnt_q    <= '0;
        serial_q <= first_bit;
      end else if (busy && !stall) begin
        if (bit_last) begin
          done_q   <= 1'b1;
          state_q  <= IDLE;
          serial_q <= IDLE_LEVEL;
        end else begin
          shreg_q  <= shreg_d;
          cnt_q    <= cnt_q + CW'(1);
          serial_q <= next_bit;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_shift_register.sv
// ---------------------------------------------------------------------------
// tb_piso_shift_register : randomized bench with a queue-based reference
// model and a behavioural loopback receiver.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_piso_shift_register;

  localparam int   WIDTH      = 4;
  localparam logic IDLE_LEVEL = 1'b0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] pin;
  logic             lv;
  logic             dir;
  logic             st;
  logic             load_ready;
  logic             serial_out;
  logic             bit_valid;
  logic             bit_last;
  logic             busy;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of bits still to be presented, current bit first.
  logic             exp_bits[$];
  logic [WIDTH:0]   words[$];
  logic             exp_done;
  logic [WIDTH-1:0] rx;

  piso_shift_register #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE_LEVEL)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .parallel_in(pin),
    .load_valid (lv),
    .load_ready (load_ready),
    .shift_dir  (dir),
    .stall      (st),
    .serial_out (serial_out),
    .bit_valid  (bit_valid),
    .bit_last   (bit_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_bits.delete();
    words.delete();
    exp_done = 1'b0;
  endtask

  task automatic model_edge();
    logic m_busy, m_last, m_ready, m_acc;
    if (!rst_n) begin
      model_clear();
      return;
    end
    m_busy   = (exp_bits.size() > 0);
    m_last   = (exp_bits.size() == 1);
    m_ready  = !m_busy || (m_last && !st);
    m_acc    = lv && m_ready;
    exp_done = m_busy && m_last && !st;
    if (m_busy && !st) begin
      void'(exp_bits.pop_front());
      if (m_last && words.size() > 0) void'(words.pop_front());
    end
    if (m_acc) begin
      for (int i = 0; i < WIDTH; i++)
        exp_bits.push_back(dir ? pin[WIDTH-1-i] : pin[i]);
      words.push_back({dir, pin});
    end
  endtask

  task automatic check_all();
    logic e_busy, e_ser;
    e_busy = (exp_bits.size() > 0);
    e_ser  = e_busy ? exp_bits[0] : IDLE_LEVEL;
    chk("busy",       busy,       e_busy);
    chk("serial_out", serial_out, e_ser);
    chk("bit_last",   bit_last,   exp_bits.size() == 1);
    chk("bit_valid",  bit_valid,  e_busy && !st);
    chk("load_ready", load_ready, !e_busy || (exp_bits.size() == 1 && !st));
    chk("done",       done,       exp_done);
    // Receiver shifts on every live bit in the direction of the word in flight.
    if (bit_valid === 1'b1 && words.size() > 0) begin
      rx = words[0][WIDTH] ? {rx[WIDTH-2:0], serial_out} : {serial_out, rx[WIDTH-1:1]};
      if (bit_last === 1'b1) chk("loopback", rx, words[0][WIDTH-1:0]);
    end
  endtask

  task automatic cycle(input logic v, input logic [WIDTH-1:0] p, input logic d, input logic s);
    lv = v; pin = p; dir = d; st = s;
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; lv = 1'b0; pin = '0; dir = 1'b0; st = 1'b0; rx = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    idle(1);
    rst_n = 1'b1;
    idle(2);

    // Single words in each direction; mid-word dir toggling must be ignored.
    cycle(1'b1, 4'b1011, 1'b0, 1'b0);
    idle(6);
    cycle(1'b1, 4'b0110, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 4'b1111, i[0], 1'b0);

    // Back-to-back words with load_valid held high.
    cycle(1'b1, 4'b1011, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0110, 1'b1, 1'b0);
    idle(6);

    // Stall for two cycles while bit 1 is presented.
    cycle(1'b1, 4'b1001, 1'b0, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0, 1'b1);
    idle(6);

    // Asynchronous reset while bit 2 is presented.
    cycle(1'b1, 4'b1111, 1'b0, 1'b0);
    idle(2);
    lv = 1'b0; st = 1'b0;
    #1;
    check_all();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy",      busy,       1'b0);
    chk("rst_serial",    serial_out, IDLE_LEVEL);
    chk("rst_bit_valid", bit_valid,  1'b0);
    chk("rst_done",      done,       1'b0);
    model_clear();
    @(posedge clk);
    #1;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    cycle(1'b1, 4'b0101, 1'b0, 1'b0);
    idle(6);

    // Loopback of the same word in both directions.
    cycle(1'b1, 4'b1101, 1'b0, 1'b0);
    idle(5);
    cycle(1'b1, 4'b1101, 1'b1, 1'b0);
    idle(5);

    // Randomized traffic with stalls and back-to-back loads.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 60,
            WIDTH'($urandom),
            1'($urandom),
            $urandom_range(0, 99) < 20);
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
